char_feeder: RTL and testbench

Upstream stage of the keyword block checker. Accepts ASCII bytes from a valid/ready source, buffers them in a small FIFO, and normalises whitespace. It emits exactly one character per clock on `out_char`, which is the checker's `in`. The output is padded with spaces whenever no data is available or the output is held. A space is a neutral separator for the checker, so padding never creates or breaks a keyword.

---
 rtl/char_feeder_if.sv | 26 ++
 rtl/char_feeder.sv | 84 ++++++++
 tb/tb_char_feeder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/char_feeder_if.sv
// Byte-stream interface between the ASCII source, the char_feeder and the keyword checker.
// The master side drives source data and control; the slave side is the feeder itself.
interface char_feeder_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          hold;
  logic          flush;
  logic [7:0]    out_char;
  logic          out_real;
  logic [LW-1:0] level;

  modport master (
    output in_data, in_valid, hold, flush,
    input  in_ready, out_char, out_real, level
  );

  modport slave (
    input  in_data, in_valid, hold, flush,
    output in_ready, out_char, out_real, level
  );
endinterface

// File: rtl/char_feeder.sv
// Buffers source bytes in a small circular FIFO, folds tab/LF/CR to space, drops NUL,
// and emits exactly one character per clock, padding with PAD whenever nothing is popped.
module char_feeder #(
  parameter int          DEPTH = 8,
  parameter logic [7:0]  PAD   = 8'h20
) (
  input  logic         clk,
  input  logic         reset,
  char_feeder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  function automatic logic [7:0] map_ws(input logic [7:0] c);
    logic [7:0] r;
    r = c;
    if (c == 8'h09 || c == 8'h0A || c == 8'h0D) r = 8'h20;
    return r;
  endfunction

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    out_char_q, out_char_d;
  logic          out_real_q, out_real_d;
  logic          push, store, pop;

  assign bus.in_ready = (level_q != LW'(DEPTH));
  assign bus.out_char = out_char_q;
  assign bus.out_real = out_real_q;
  assign bus.level    = level_q;

  // A NUL or a byte arriving during flush completes the handshake but never lands in the buffer.
  assign push  = bus.in_valid && bus.in_ready;
  assign store = push && (bus.in_data != 8'h00) && !bus.flush;
  assign pop   = !bus.hold && (level_q != '0) && !bus.flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    out_char_d = PAD;
    out_real_d = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        out_char_d = mem_q[rd_ptr_q];
        out_real_d = 1'b1;
      end
      case ({store, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_char_q <= PAD;
      out_real_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_char_q <= out_char_d;
      out_real_q <= out_real_d;
    end
  end

  // Buffer contents are don't-care after reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= map_ws(bus.in_data);
  end
endmodule

// File: tb/tb_char_feeder.sv
// Bench for char_feeder: directed vector table, hand-written corner sequences and a
// randomized stream checked against a queue-based reference model.
module tb_char_feeder;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  char_feeder_if #(.DEPTH(DEPTH)) bus ();

  char_feeder #(.DEPTH(DEPTH), .PAD(8'h20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_real = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] exp_char;
  logic       exp_real;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       h;
    logic       f;
    logic [7:0] ec;
    logic       er;
    logic [3:0] el;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic h, input logic f,
                     input logic [7:0] ec, input logic er, input logic [3:0] el);
    vec_t t;
    t.v = v; t.d = d; t.h = h; t.f = f; t.ec = ec; t.er = er; t.el = el;
    tbl.push_back(t);
  endtask

  function automatic logic [7:0] model_map(input logic [7:0] c);
    if (c == 8'h09 || c == 8'h0A || c == 8'h0D) return 8'h20;
    return c;
  endfunction

  // One clock of stimulus checked against the queue model; returns whether the byte was taken.
  task automatic step(input logic v, input logic [7:0] d, input logic h, input logic f,
                      output logic taken);
    logic rdy;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.hold     = h;
    bus.flush    = f;
    #1;
    rdy = (q.size() != DEPTH);
    chk("in_ready", bus.in_ready, rdy);
    taken = v && rdy;
    @(posedge clk);
    exp_char = 8'h20;
    exp_real = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      if (!h && q.size() != 0) begin
        exp_char = q.pop_front();
        exp_real = 1'b1;
      end
      if (taken && d != 8'h00) q.push_back(model_map(d));
    end
    #1;
    chk("out_char", bus.out_char, exp_char);
    chk("out_real", bus.out_real, exp_real);
    chk("level", bus.level, q.size());
    if (bus.out_real === 1'b1) n_real++;
  endtask

  task automatic idle(input int n, input logic h);
    logic t;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, h, 1'b0, t);
  endtask

  initial begin
    logic       t;
    logic [7:0] s[8];
    logic       src_v;
    logic [7:0] src_d;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.hold     = 1'b0;
    bus.flush    = 1'b0;
    reset = 1'b1;
    #12;
    chk("rst_out_char", bus.out_char, 8'h20);
    chk("rst_out_real", bus.out_real, 1'b0);
    chk("rst_level", bus.level, 0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed vectors: idle, "BEGIN" back-to-back, then NUL / LF / 'x'
    for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 0, 8'h20, 0, 0);
    add(1, "B", 0, 0, 8'h20, 0, 1);
    add(1, "E", 0, 0, "B",   1, 1);
    add(1, "G", 0, 0, "E",   1, 1);
    add(1, "I", 0, 0, "G",   1, 1);
    add(1, "N", 0, 0, "I",   1, 1);
    add(0, 8'h00, 0, 0, "N", 1, 0);
    add(0, 8'h00, 0, 0, 8'h20, 0, 0);
    add(1, 8'h00, 0, 0, 8'h20, 0, 0);
    add(1, 8'h0A, 0, 0, 8'h20, 0, 1);
    add(1, "x",   0, 0, 8'h20, 1, 1);
    add(0, 8'h00, 0, 0, "x",   1, 0);
    add(0, 8'h00, 0, 0, 8'h20, 0, 0);
    foreach (tbl[i]) begin
      bus.in_valid = tbl[i].v;
      bus.in_data  = tbl[i].d;
      bus.hold     = tbl[i].h;
      bus.flush    = tbl[i].f;
      #1;
      chk("vec_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      chk("vec_out_char", bus.out_char, tbl[i].ec);
      chk("vec_out_real", bus.out_real, tbl[i].er);
      chk("vec_level", bus.level, tbl[i].el);
    end

    // Fill to full under hold, present a ninth byte, then release hold
    s[0] = "e"; s[1] = "n"; s[2] = "d"; s[3] = 8'h09;
    s[4] = "E"; s[5] = "N"; s[6] = "D"; s[7] = "!";
    for (int i = 0; i < 8; i++) step(1'b1, s[i], 1'b1, 1'b0, t);
    chk("full_level", bus.level, DEPTH);
    chk("full_ready", bus.in_ready, 1'b0);
    step(1'b1, "?", 1'b1, 1'b0, t);
    chk("full_not_taken", t, 1'b0);
    t = 1'b0;
    for (int i = 0; i < 4 && !t; i++) step(1'b1, "?", 1'b0, 1'b0, t);
    chk("late_push_taken", t, 1'b1);
    idle(10, 1'b0);

    // Flush with a concurrent push discards everything
    for (int i = 0; i < 5; i++) step(1'b1, 8'h41 + 8'(i), 1'b1, 1'b0, t);
    step(1'b1, "Q", 1'b1, 1'b1, t);
    chk("flush_level", bus.level, 0);
    chk("flush_real", bus.out_real, 1'b0);
    n_real = 0;
    idle(4, 1'b0);
    chk("flush_no_output", n_real, 0);

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) step(1'b1, 8'h61 + 8'(i), 1'b1, 1'b0, t);
    bus.in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    q.delete();
    chk("arst_out_char", bus.out_char, 8'h20);
    chk("arst_out_real", bus.out_real, 1'b0);
    chk("arst_level", bus.level, 0);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    n_real = 0;
    step(1'b1, "E", 1'b0, 1'b0, t);
    idle(1, 1'b0);
    chk("arst_E", exp_char, "E");
    idle(4, 1'b0);
    chk("arst_one_real", n_real, 1);

    // Randomized stream; the source keeps its byte until accepted
    src_v = 1'b0;
    src_d = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (!src_v) begin
        src_v = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 9))
          0:       src_d = 8'h00;
          1:       src_d = 8'h09;
          2:       src_d = 8'h0A;
          3:       src_d = 8'h0D;
          default: src_d = 8'($urandom_range(8'h21, 8'h7E));
        endcase
      end
      step(src_v, src_d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0), t);
      if (t) src_v = 1'b0;
    end
    idle(DEPTH + 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
